// File: rtl/dmux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmux_pkg : shared constants and state type for the 1-to-4 dispatcher |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmux_pkg;

   localparam int NCH  = 4;
   localparam int SELW = 2;

   localparam logic [SELW-1:0] CH_A = 2'd0;
   localparam logic [SELW-1:0] CH_B = 2'd1;
   localparam logic [SELW-1:0] CH_C = 2'd2;
   localparam logic [SELW-1:0] CH_D = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : first requesting channel at or after start, mod NCH        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick
   import dmux_pkg::*;
(
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] start,
   input  logic [SELW-1:0] excl,
   input  logic            excl_en,
   output logic [SELW-1:0] idx,
   output logic            found
);

   logic [SELW-1:0] w_cand;

   // Walk from the farthest offset back to start so the nearest hit wins.
   always_comb begin
      idx    = start;
      found  = 1'b0;
      w_cand = start;
      for (int i = NCH - 1; i >= 0; i--) begin
         w_cand = start + SELW'(i);
         if (req[w_cand] && !(excl_en && (w_cand == excl))) begin
            idx   = w_cand;
            found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmux_rr_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmux_rr_dispatcher : registered valid/ready 1-to-4 word dispatcher   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmux_rr_dispatcher
   import dmux_pkg::*;
#(
   parameter int DW      = 4,
   parameter int TIMEOUT = 15,
   parameter int CW      = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DW-1:0]   in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            cfg_mode,
   input  logic [1:0]      cfg_sel,
   input  logic [NCH-1:0]  out_ready,
   output logic [NCH-1:0]  out_valid,
   output logic [DW-1:0]   a,
   output logic [DW-1:0]   b,
   output logic [DW-1:0]   c,
   output logic [DW-1:0]   d,
   output logic [1:0]      sel,
   output logic            busy,
   output logic            skip
);

   state_t          r_state;
   logic [SELW-1:0] r_tgt;
   logic [SELW-1:0] r_ptr;
   logic [DW-1:0]   r_word;
   logic [CW-1:0]   r_cnt;
   logic            r_mode;
   logic            r_skip;

   logic            w_send;
   logic            w_done;
   logic            w_accept;
   logic [SELW-1:0] w_tgt_inc;
   logic [SELW-1:0] w_start;
   logic [SELW-1:0] w_new_idx;
   logic            w_new_found;
   logic [SELW-1:0] w_new_tgt;
   logic [SELW-1:0] w_to_idx;
   logic            w_to_found;
   logic [CW-1:0]   w_cnt_inc;

   assign w_send    = (r_state == ST_SEND);
   assign w_done    = w_send && out_ready[r_tgt];
   assign in_ready  = !w_send || out_ready[r_tgt];
   assign w_accept  = in_valid && in_ready;
   assign w_tgt_inc = r_tgt + 1'b1;
   // A word accepted in the completing cycle must see the advanced pointer.
   assign w_start   = w_done ? w_tgt_inc : r_ptr;
   assign w_cnt_inc = r_cnt + 1'b1;

   rr_pick u_pick_new (
      .req     (out_ready),
      .start   (w_start),
      .excl    (r_tgt),
      .excl_en (1'b0),
      .idx     (w_new_idx),
      .found   (w_new_found)
   );

   rr_pick u_pick_timeout (
      .req     (out_ready),
      .start   (w_tgt_inc),
      .excl    (r_tgt),
      .excl_en (1'b1),
      .idx     (w_to_idx),
      .found   (w_to_found)
   );

   assign w_new_tgt = cfg_mode ? (w_new_found ? w_new_idx : w_start) : cfg_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_tgt   <= '0;
         r_ptr   <= '0;
         r_word  <= '0;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
         r_skip  <= 1'b0;
      end else begin
         r_skip <= 1'b0;
         if (w_done) begin
            r_ptr <= w_tgt_inc;
         end
         if (w_accept) begin
            r_state <= ST_SEND;
            r_word  <= in_data;
            r_tgt   <= w_new_tgt;
            r_mode  <= cfg_mode;
            r_cnt   <= '0;
         end else if (w_done) begin
            r_state <= ST_IDLE;
         end else if (w_send) begin
            if (r_mode) begin
               if (w_cnt_inc == CW'(TIMEOUT)) begin
                  r_cnt <= '0;
                  if (w_to_found) begin
                     r_tgt  <= w_to_idx;
                     r_skip <= 1'b1;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end else if (!(&r_cnt)) begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_valid
      assign out_valid[i] = w_send && (r_tgt == SELW'(i));
   end

   assign a    = out_valid[CH_A] ? r_word : '0;
   assign b    = out_valid[CH_B] ? r_word : '0;
   assign c    = out_valid[CH_C] ? r_word : '0;
   assign d    = out_valid[CH_D] ? r_word : '0;
   assign sel  = r_tgt;
   assign busy = w_send;
   assign skip = r_skip;

endmodule
`default_nettype wire
